// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared types and encodings for the next-PC / fetch sequencing logic
//
// Purpose: state enum for fetch_sequencer, pc_sel encodings, trap cause codes.
// Ports: none (package).
package npc_pkg;

  typedef enum logic [2:0] {
    FSEQ_RESET  = 3'd0,
    FSEQ_REQ    = 3'd1,
    FSEQ_WAIT   = 3'd2,
    FSEQ_EXEC   = 3'd3,
    FSEQ_UPDATE = 3'd4,
    FSEQ_TRAP   = 3'd5,
    FSEQ_HALT   = 3'd6
  } fseq_state_t;

  // pc_sel encodings; 2'b10 is also decoded as the adder by the PC mux.
  localparam logic [1:0] PC_SEL_ADDER = 2'b00;
  localparam logic [1:0] PC_SEL_MTVEC = 2'b01;
  localparam logic [1:0] PC_SEL_MEPC  = 2'b11;

  localparam logic [3:0] CAUSE_INST_ACCESS_FAULT = 4'd1;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory request/response handshake bundle
//
// Purpose: groups the imem request and response channels.
// Ports (master = fetch_sequencer, slave = instruction memory):
//   imem_req_valid/imem_req_ready/imem_req_addr : request channel
//   imem_rsp_valid/imem_rsp_ready/imem_rsp_data/imem_rsp_err : response channel
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic              imem_rsp_ready;
  logic [31:0]       imem_rsp_data;
  logic              imem_rsp_err;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
endinterface

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - 8-bit response-timeout counter with terminal-count flag
//
// Purpose: counts cycles spent waiting for an imem response.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (has priority over inc)
//   inc      : advance the counter by one
//   tc       : this cycle is the TIMEOUT-th counted cycle since clear
module fetch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (inc) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // The first waiting cycle sees count 0, so the TIMEOUT-th sees TIMEOUT-1.
  assign tc = ({1'b0, count_q} + 9'd1) == 9'(TIMEOUT);
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/execute/commit control FSM driving the PC register
//
// Purpose: requests instructions at pc, hands them to execute, commits next PC,
// raises instruction-access-fault traps, counts retired instructions, parks on halt.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc              : current PC from the PC register
//   imem            : imem request/response bundle (master side)
//   inst/inst_valid : latched instruction to decode/execute
//   exu_done/exu_pc_sel/exu_adder_sel/halt : execute completion and next-PC selects
//   pc_we/pc_sel/adder_sel : PC register write enable and mux selects
//   trap_req/trap_cause    : trap request to the CSR unit
//   halted, instret        : parked flag, retired-instruction count
module fetch_sequencer
  import npc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  fetch_sequencer_if.master imem,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              exu_done,
  input  logic [1:0]        exu_pc_sel,
  input  logic [1:0]        exu_adder_sel,
  input  logic              halt,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [1:0]        adder_sel,
  output logic              trap_req,
  output logic [3:0]        trap_cause,
  output logic              halted,
  output logic [63:0]       instret
);
  fseq_state_t state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [1:0]  pc_sel_q, pc_sel_d;
  logic [1:0]  adder_sel_q, adder_sel_d;
  logic [63:0] instret_q, instret_d;
  logic        timer_tc;

  // Cleared while requesting so WAIT always starts from zero.
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q == FSEQ_REQ),
    .inc (state_q == FSEQ_WAIT),
    .tc  (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FSEQ_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q      <= 32'd0;
      pc_sel_q    <= PC_SEL_ADDER;
      adder_sel_q <= 2'b00;
      instret_q   <= 64'd0;
    end else begin
      inst_q      <= inst_d;
      pc_sel_q    <= pc_sel_d;
      adder_sel_q <= adder_sel_d;
      instret_q   <= instret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    pc_sel_d    = pc_sel_q;
    adder_sel_d = adder_sel_q;
    instret_d   = instret_q;
    case (state_q)
      FSEQ_RESET: state_d = FSEQ_REQ;
      FSEQ_REQ: begin
        if (imem.imem_req_ready) state_d = FSEQ_WAIT;
      end
      FSEQ_WAIT: begin
        // A response in the timeout cycle still wins.
        if (imem.imem_rsp_valid) begin
          if (imem.imem_rsp_err) begin
            state_d = FSEQ_TRAP;
          end else begin
            inst_d  = imem.imem_rsp_data;
            state_d = FSEQ_EXEC;
          end
        end else if (timer_tc) begin
          state_d = FSEQ_TRAP;
        end
      end
      FSEQ_EXEC: begin
        if (exu_done) begin
          if (halt) begin
            state_d = FSEQ_HALT;
          end else begin
            pc_sel_d    = exu_pc_sel;
            adder_sel_d = exu_adder_sel;
            state_d     = FSEQ_UPDATE;
          end
        end
      end
      FSEQ_UPDATE: begin
        instret_d = instret_q + 64'd1;
        state_d   = FSEQ_REQ;
      end
      FSEQ_TRAP: state_d = FSEQ_REQ;
      FSEQ_HALT: state_d = FSEQ_HALT;
      default:   state_d = FSEQ_RESET;
    endcase
  end

  always_comb begin
    imem.imem_req_valid = 1'b0;
    imem.imem_rsp_ready = 1'b0;
    inst_valid          = 1'b0;
    pc_we               = 1'b0;
    pc_sel              = PC_SEL_ADDER;
    adder_sel           = 2'b00;
    trap_req            = 1'b0;
    trap_cause          = 4'd0;
    halted              = 1'b0;
    case (state_q)
      FSEQ_REQ:  imem.imem_req_valid = 1'b1;
      FSEQ_WAIT: imem.imem_rsp_ready = 1'b1;
      FSEQ_EXEC: inst_valid = 1'b1;
      FSEQ_UPDATE: begin
        pc_we     = 1'b1;
        pc_sel    = pc_sel_q;
        adder_sel = adder_sel_q;
      end
      FSEQ_TRAP: begin
        pc_we      = 1'b1;
        pc_sel     = PC_SEL_MTVEC;
        trap_req   = 1'b1;
        trap_cause = CAUSE_INST_ACCESS_FAULT;
      end
      FSEQ_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign imem.imem_req_addr = pc;
  assign inst               = inst_q;
  assign instret            = instret_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exu_done;
  logic [1:0]  exu_pc_sel;
  logic [1:0]  exu_adder_sel;
  logic        halt;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [1:0]  adder_sel;
  logic        trap_req;
  logic [3:0]  trap_cause;
  logic        halted;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer_if #(.ADDR_W(32)) imem_if ();

  fetch_sequencer #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .imem          (imem_if),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .exu_done      (exu_done),
    .exu_pc_sel    (exu_pc_sel),
    .exu_adder_sel (exu_adder_sel),
    .halt          (halt),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .adder_sel     (adder_sel),
    .trap_req      (trap_req),
    .trap_cause    (trap_cause),
    .halted        (halted),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc = 32'h8000_0000;
    exu_done = 1'b0; exu_pc_sel = 2'b00; exu_adder_sel = 2'b00; halt = 1'b0;
    imem_if.imem_req_ready = 1'b0;
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_data  = 32'd0;
    imem_if.imem_rsp_err   = 1'b0;

    // Reset sequence: RESET -> REQ -> WAIT -> EXEC -> UPDATE
    step();
    check("rst_req_valid", imem_if.imem_req_valid, 0);
    check("rst_rsp_ready", imem_if.imem_rsp_ready, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_trap", trap_req, 0);
    check("rst_halted", halted, 0);
    check("rst_inst", inst, 0);
    check("rst_instret", instret, 0);
    check("rst_addr", imem_if.imem_req_addr, 32'h8000_0000);
    rst = 1'b0;
    step();
    check("c2_req_valid", imem_if.imem_req_valid, 1);
    check("c2_addr", imem_if.imem_req_addr, 32'h8000_0000);
    imem_if.imem_req_ready = 1'b1;
    step();
    check("c3_wait_rsp_ready", imem_if.imem_rsp_ready, 1);
    check("c3_req_valid", imem_if.imem_req_valid, 0);
    imem_if.imem_req_ready = 1'b0;
    imem_if.imem_rsp_valid = 1'b1;
    imem_if.imem_rsp_data  = 32'h0010_0093;
    step();
    check("c4_inst_valid", inst_valid, 1);
    check("c4_inst", inst, 32'h0010_0093);
    check("c4_pc_we", pc_we, 0);
    imem_if.imem_rsp_valid = 1'b0;
    exu_done = 1'b1;
    step();
    check("c5_pc_we", pc_we, 1);
    check("c5_pc_sel", pc_sel, 2'b00);
    check("c5_adder_sel", adder_sel, 2'b00);
    check("c5_instret", instret, 0);
    exu_done = 1'b0;
    pc = 32'h8000_0004;
    step();
    check("c6_instret", instret, 1);
    check("c6_pc_we", pc_we, 0);
    check("c6_req_valid", imem_if.imem_req_valid, 1);

    // Backpressure: ready low for 3 request cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_req_valid", imem_if.imem_req_valid, 1);
      check("bp_addr", imem_if.imem_req_addr, 32'h8000_0004);
    end
    imem_if.imem_req_ready = 1'b1;
    step();
    check("bp_accepted_wait", imem_if.imem_rsp_ready, 1);
    check("bp_single_req", imem_if.imem_req_valid, 0);
    imem_if.imem_req_ready = 1'b0;

    // Bus error
    imem_if.imem_rsp_valid = 1'b1;
    imem_if.imem_rsp_err   = 1'b1;
    imem_if.imem_rsp_data  = 32'hdead_beef;
    step();
    check("berr_trap_req", trap_req, 1);
    check("berr_cause", trap_cause, 4'd1);
    check("berr_pc_sel", pc_sel, 2'b01);
    check("berr_pc_we", pc_we, 1);
    check("berr_adder_sel", adder_sel, 2'b00);
    check("berr_inst_kept", inst, 32'h0010_0093);
    check("berr_instret", instret, 1);
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_err   = 1'b0;
    pc = 32'h0000_0100;
    step();
    check("berr_one_cycle", trap_req, 0);
    check("berr_cause_clr", trap_cause, 0);
    check("berr_req_addr", imem_if.imem_req_addr, 32'h0000_0100);
    check("berr_instret_after", instret, 1);

    // Timeout with no response: TRAP 4 cycles after WAIT entry
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_in_wait", imem_if.imem_rsp_ready, 1);
      check("to_no_trap", trap_req, 0);
      step();
    end
    check("to_trap", trap_req, 1);
    check("to_cause", trap_cause, 4'd1);
    step();
    check("to_back_req", imem_if.imem_req_valid, 1);

    // Response on the 4th WAIT cycle wins over timeout
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("late_rsp_wait", imem_if.imem_rsp_ready, 1);
    imem_if.imem_rsp_valid = 1'b1;
    imem_if.imem_rsp_data  = 32'h0000_0013;
    step();
    check("late_rsp_exec", inst_valid, 1);
    check("late_rsp_no_trap", trap_req, 0);
    check("late_rsp_inst", inst, 32'h0000_0013);
    check("exec_rsp_ignored", imem_if.imem_rsp_ready, 0);

    // mret: pc_sel 11, adder_sel passed through
    imem_if.imem_rsp_valid = 1'b0;
    exu_done = 1'b1; exu_pc_sel = 2'b11; exu_adder_sel = 2'b10;
    step();
    check("mret_pc_sel", pc_sel, 2'b11);
    check("mret_adder_sel", adder_sel, 2'b10);
    check("mret_pc_we", pc_we, 1);
    exu_done = 1'b0; exu_pc_sel = 2'b00; exu_adder_sel = 2'b00;
    imem_if.imem_rsp_valid = 1'b1;
    imem_if.imem_rsp_data  = 32'h0010_0073;
    step();
    check("mret_instret", instret, 2);
    check("req_rsp_ignored", imem_if.imem_rsp_ready, 0);
    check("req_pc_sel_idle", pc_sel, 2'b00);

    // Halt: exu_done + halt parks the core
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    step();
    check("halt_pre_exec", inst_valid, 1);
    imem_if.imem_rsp_valid = 1'b0;
    exu_done = 1'b1; halt = 1'b1; exu_pc_sel = 2'b10;
    step();
    imem_if.imem_req_ready = 1'b1;
    imem_if.imem_rsp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", halted, 1);
      check("halt_no_pc_we", pc_we, 0);
      check("halt_no_req", imem_if.imem_req_valid, 0);
      check("halt_instret", instret, 2);
      step();
    end
    exu_done = 1'b0; halt = 1'b0; exu_pc_sel = 2'b00;
    imem_if.imem_rsp_valid = 1'b0;

    // Reset mid-WAIT, late response ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_halted_clr", halted, 0);
    check("rst2_instret", instret, 0);
    step();
    step();
    imem_if.imem_req_ready = 1'b0;
    step();
    check("midwait_in_wait", imem_if.imem_rsp_ready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_if.imem_rsp_valid = 1'b1;
    imem_if.imem_rsp_data  = 32'h1234_5678;
    check("midwait_reset_state", imem_if.imem_rsp_ready, 0);
    step();
    check("midwait_restart_req", imem_if.imem_req_valid, 1);
    check("midwait_inst_clr", inst, 0);
    check("midwait_no_exec", inst_valid, 0);
    step();
    check("midwait_still_req", imem_if.imem_req_valid, 1);

    // pc_sel 10 passes through unchanged
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    step();
    check("ps10_exec_inst", inst, 32'h1234_5678);
    imem_if.imem_rsp_valid = 1'b0;
    exu_done = 1'b1; exu_pc_sel = 2'b10; exu_adder_sel = 2'b01;
    step();
    check("ps10_pc_sel", pc_sel, 2'b10);
    check("ps10_adder_sel", adder_sel, 2'b01);
    exu_done = 1'b0;
    step();
    check("ps10_instret", instret, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
